// File: rtl/ps2_key_monitor.sv
// rtl/ps2_key_monitor.sv - PS/2 make/break/extended decoder with BCD press count and hex display
// Drains the receiver FIFO with a 3-cycle pop handshake and tracks the currently held key.
module ps2_key_monitor #(
  parameter int CNT_DIGITS       = 2,
  parameter bit BLANK_ON_RELEASE = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [7:0]                  i_data,
  input  logic                        i_ready,
  input  logic                        i_overflow,
  output logic                        o_nextdata_n,
  output logic [7:0]                  o_scan_code,
  output logic                        o_ext,
  output logic                        o_key_held,
  output logic [4*CNT_DIGITS-1:0]     o_press_cnt,
  output logic                        o_overflow_seen,
  output logic [7*(2+CNT_DIGITS)-1:0] o_hex
);

  typedef enum logic [1:0] {H_IDLE, H_POP, H_WAIT} state_t;

  state_t                        r_state, w_next;
  logic [7:0]                    r_byte;
  logic                          r_brk_p, r_ext_p;
  logic [7:0]                    r_scan_code;
  logic                          r_ext, r_key_held;
  logic [4*CNT_DIGITS-1:0]       r_press_cnt;
  logic                          r_overflow_seen;
  logic                          r_nextdata_n;
  logic [7*(2+CNT_DIGITS)-1:0]   r_hex, w_hex, w_hex_rst;
  logic                          w_match;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
  endfunction

  // Ripple carry across BCD digits; all-nines rolls over to zero.
  function automatic logic [4*CNT_DIGITS-1:0] bcd_inc(input logic [4*CNT_DIGITS-1:0] v);
    logic carry;
    bcd_inc = v;
    carry   = 1'b1;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= H_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      H_IDLE:  if (i_ready) w_next = H_POP;
      H_POP:   w_next = H_WAIT;
      H_WAIT:  w_next = H_IDLE;
      default: w_next = H_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte       <= 8'h00;
      r_nextdata_n <= 1'b1;
    end else begin
      if (r_state == H_IDLE && i_ready) r_byte <= i_data;
      r_nextdata_n <= (r_state != H_POP);
    end
  end

  assign w_match = ({r_ext_p, r_byte} == {r_ext, r_scan_code});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_brk_p         <= 1'b0;
      r_ext_p         <= 1'b0;
      r_scan_code     <= 8'h00;
      r_ext           <= 1'b0;
      r_key_held      <= 1'b0;
      r_press_cnt     <= '0;
      r_overflow_seen <= 1'b0;
    end else begin
      r_overflow_seen <= r_overflow_seen | i_overflow;
      if (r_state == H_POP) begin
        if (r_byte == 8'hE0) begin
          r_ext_p <= 1'b1;
        end else if (r_byte == 8'hF0) begin
          r_brk_p <= 1'b1;
        end else begin
          r_brk_p <= 1'b0;
          r_ext_p <= 1'b0;
          if (r_brk_p) begin
            if (r_key_held && w_match) r_key_held <= 1'b0;
          end else if (!r_key_held || !w_match) begin
            r_scan_code <= r_byte;
            r_ext       <= r_ext_p;
            r_key_held  <= 1'b1;
            r_press_cnt <= bcd_inc(r_press_cnt);
          end
        end
      end
    end
  end

  always_comb begin
    w_hex     = '0;
    w_hex_rst = '0;
    w_hex[6:0]      = (BLANK_ON_RELEASE && !r_key_held) ? 7'h7F : seg(r_scan_code[3:0]);
    w_hex[13:7]     = (BLANK_ON_RELEASE && !r_key_held) ? 7'h7F : seg(r_scan_code[7:4]);
    w_hex_rst[6:0]  = BLANK_ON_RELEASE ? 7'h7F : 7'h40;
    w_hex_rst[13:7] = BLANK_ON_RELEASE ? 7'h7F : 7'h40;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      w_hex[7*(i+2) +: 7]     = seg(r_press_cnt[4*i +: 4]);
      w_hex_rst[7*(i+2) +: 7] = 7'h40;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_hex <= w_hex_rst;
    else       r_hex <= w_hex;
  end

  assign o_nextdata_n    = r_nextdata_n;
  assign o_scan_code     = r_scan_code;
  assign o_ext           = r_ext;
  assign o_key_held      = r_key_held;
  assign o_press_cnt     = r_press_cnt;
  assign o_overflow_seen = r_overflow_seen;
  assign o_hex           = r_hex;

endmodule
